// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Byte-serial command front-end for the 8-bit combinational ALU.
// A command is a header byte followed by operand A and operand B.
//
// Header byte layout:
//   [2:0] ALU control
//   [6:3] shift amount
//   [7]   chain
//
// With chain set, operand A is taken from the last result (the accumulator)
// and the A beat is skipped. Operands are registered onto the ALU ports.
// The ALU result and flags are captured after one EXEC cycle and presented
// downstream on a valid/ready port.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_data/valid/ready   upstream byte stream (valid/ready handshake)
//   alu_a, alu_b          registered operands to the ALU
//   alu_ctrl, alu_samt    registered control and shift amount to the ALU
//   alu_result, alu_flags combinational ALU response;
//                         flags are {OVERFLOW, NEGATIVE, ZERO, CARRY}
//   out_result/flags      captured response, held until the next EXEC
//   out_valid, out_ready  downstream handshake
//   busy                  high whenever not waiting for a header
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter bit CHAIN_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_ctrl,
    output logic [3:0] alu_samt,
    input  logic [7:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic [7:0] out_result,
    output logic [3:0] out_flags,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_HDR,
        S_OPA,
        S_OPB,
        S_EXEC,
        S_OUT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [2:0] ctrl_q, ctrl_d;
    logic [3:0] samt_q, samt_d;
    logic [7:0] res_q, res_d;
    logic [3:0] flags_q, flags_d;
    logic [7:0] acc_q, acc_d;
    logic       accept;
    logic       chain_eff;

    // in_ready depends on state only, so out_ready never reaches it
    // combinationally.
    assign in_ready = (state_q == S_HDR) || (state_q == S_OPA) || (state_q == S_OPB);
    assign accept   = in_valid && in_ready;

    // With chaining disabled, header bit 7 is ignored.
    assign chain_eff = CHAIN_EN ? in_data[7] : 1'b0;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        samt_d  = samt_q;
        res_d   = res_q;
        flags_d = flags_q;
        acc_d   = acc_q;
        case (state_q)
            S_HDR: begin
                if (accept) begin
                    ctrl_d = in_data[2:0];
                    samt_d = in_data[6:3];
                    if (chain_eff) begin
                        a_d     = acc_q;
                        state_d = S_OPB;
                    end else begin
                        state_d = S_OPA;
                    end
                end
            end
            S_OPA: begin
                if (accept) begin
                    a_d     = in_data;
                    state_d = S_OPB;
                end
            end
            S_OPB: begin
                if (accept) begin
                    b_d     = in_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // The ALU has had the whole cycle to settle on the registered operands.
                res_d   = alu_result;
                flags_d = alu_flags;
                acc_d   = alu_result;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HDR;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            samt_q  <= '0;
            res_q   <= '0;
            flags_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            samt_q  <= samt_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            acc_q   <= acc_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ctrl_q;
    assign alu_samt   = samt_q;
    assign out_result = res_q;
    assign out_flags  = flags_q;
    // OUT is entered exactly at the edge that ends EXEC, so this is a registered valid.
    assign out_valid  = (state_q == S_OUT);
    assign busy       = (state_q != S_HDR);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer.
// Expected responses are queued as commands are issued.
// A monitor pops and compares them on every output handshake.
// The ALU is a small stand-in model:
//   000 add
//   001 subtract (carry = no borrow)
//   100 (A+B) << s_amt
//   other codes: AND
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_ctrl;
    logic [3:0] alu_samt;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic [7:0] out_result;
    logic [3:0] out_flags;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.CHAIN_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_samt(alu_samt),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .out_result(out_result), .out_flags(out_flags),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    // Stand-in combinational ALU; flags are {V, N, Z, C}.
    always_comb begin
        logic [8:0] s;
        s         = 9'd0;
        alu_flags = 4'd0;
        case (alu_ctrl)
            3'b000: begin
                s = {1'b0, alu_a} + {1'b0, alu_b};
                alu_flags[0] = s[8];
                alu_flags[3] = (alu_a[7] == alu_b[7]) && (s[7] != alu_a[7]);
            end
            3'b001: begin
                s = {1'b0, alu_a} - {1'b0, alu_b};
                alu_flags[0] = (alu_a >= alu_b);
                alu_flags[3] = (alu_a[7] != alu_b[7]) && (s[7] != alu_a[7]);
            end
            3'b100:  s = {1'b0, (alu_a + alu_b) << alu_samt};
            default: s = {1'b0, alu_a & alu_b};
        endcase
        alu_result   = s[7:0];
        alu_flags[2] = s[7];
        alu_flags[1] = (s[7:0] == 8'd0);
    end

    // Monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [11:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected output res=%h flags=%b", out_result, out_flags);
            end else begin
                e = exp_q.pop_front();
                if ({out_result, out_flags} !== e) begin
                    errors++;
                    $display("FAIL scoreboard: got res=%h flags=%b, expected res=%h flags=%b",
                             out_result, out_flags, e[11:4], e[3:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one byte; return #1 after the edge that accepts it.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h never accepted", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", {15'd0, busy}, 16'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  {15'd0, in_ready},  16'd1);
        chk({tag, "_busy"},      {15'd0, busy},      16'd0);
        chk({tag, "_out_valid"}, {15'd0, out_valid}, 16'd0);
        chk({tag, "_alu_ab"},    {alu_a, alu_b},     16'd0);
        chk({tag, "_ctrl_samt"}, {9'd0, alu_ctrl, alu_samt}, 16'd0);
        chk({tag, "_out"},       {4'd0, out_result, out_flags}, 16'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_vals("reset");

        // Chain straight after reset: A comes from the zeroed accumulator.
        exp_q.push_back({8'h07, 4'b0000});
        send(8'h80);
        chk("chain0_alu_a", {8'd0, alu_a}, 16'h0000);
        send(8'h07);
        wait_idle();

        // Add 5+3; out_valid rises exactly one edge after the B accept.
        exp_q.push_back({8'h08, 4'b0000});
        send(8'h00);
        send(8'h05);
        send(8'h03);
        chk("add_valid_exec", {15'd0, out_valid}, 16'd0);
        chk("add_ready_exec", {15'd0, in_ready},  16'd0);
        @(posedge clk);
        #1;
        chk("add_valid_out", {15'd0, out_valid}, 16'd1);
        wait_idle();

        // Chain: two beats; A comes from the accumulator (0x08).
        exp_q.push_back({8'h09, 4'b0000});
        send(8'h80);
        chk("chain_alu_a", {8'd0, alu_a}, 16'h0008);
        chk("chain_in_opb", {14'd0, busy, in_ready}, 16'h0003);
        send(8'h01);
        chk("chain_two_beats", {15'd0, in_ready}, 16'd0);
        wait_idle();

        // Shift: ctrl=100, s_amt=2 -> (3+1)<<2 = 0x10.
        exp_q.push_back({8'h10, 4'b0000});
        send(8'h14);
        send(8'h03);
        send(8'h01);
        chk("shift_ctrl_samt", {9'd0, alu_ctrl, alu_samt}, {9'd0, 3'b100, 4'd2});
        wait_idle();

        // Subtract, equal operands, under backpressure.
        out_ready = 1'b0;
        exp_q.push_back({8'h00, 4'b0011});
        send(8'h01);
        send(8'h03);
        send(8'h03);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = i[0] ? 8'hAA : 8'h55;
            @(posedge clk);
            #1;
            chk("bp_ready_busy", {14'd0, in_ready, busy}, 16'h0001);
            chk("bp_valid", {15'd0, out_valid}, 16'd1);
            chk("bp_hold", {4'd0, out_result, out_flags}, {4'd0, 8'h00, 4'b0011});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", {14'd0, out_valid, in_ready}, 16'h0001);

        // Subtract, negative result.
        exp_q.push_back({8'hFE, 4'b0100});
        send(8'h01);
        send(8'h03);
        send(8'h05);
        wait_idle();

        // Reset mid-command, with a byte presented during reset.
        send(8'h01);
        send(8'h7F);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_reset_vals("midrst");

        exp_q.push_back({8'h00, 4'b0011});
        send(8'h00);
        send(8'hFF);
        send(8'h01);
        wait_idle();

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end for the 8-bit ALU. Accepts a byte-serial command stream (header, operand A, operand B) over a valid/ready handshake, registers the operands onto the ALU input ports, and captures the ALU result and flags one cycle later. It presents the captured word downstream on a second valid/ready port. It keeps the last result as an accumulator, so chained operations can skip the A beat.

## Interface
Parameters:
- CHAIN_EN, default 1: 1 enables header bit 7 (chain mode). 0 forces every command to use three beats.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- in_data  in  8  command/operand byte
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer can accept a byte
- alu_a  out  8  registered operand A to ALU
- alu_b  out  8  registered operand B to ALU
- alu_ctrl  out  3  registered ALU_control
- alu_samt  out  4  registered shift amount
- alu_result  in  8  ALU RESULT (combinational from alu_* outputs)
- alu_flags  in  4  {OVERFLOW, NEGATIVE, ZERO, CARRY} from ALU
- out_result  out  8  captured result
- out_flags  out  4  captured flags, same order as alu_flags
- out_valid  out  1  out_result/out_flags valid
- out_ready  in  1  downstream accepts
- busy  out  1  high in any state other than HDR

## Operation
- Header byte layout:
  - [2:0] = ctrl
  - [6:3] = s_amt
  - [7] = chain; effective only when CHAIN_EN=1
- A byte is accepted when in_valid and in_ready are both high at a rising edge. A byte presented while in_ready is low is ignored and not stored.
- State machine:
  - HDR: in_ready=1. On accept, latch ctrl and s_amt. Go to OPB if chain is effective, loading alu_a from the accumulator; otherwise go to OPA.
  - OPA: in_ready=1. On accept, alu_a ← in_data, go to OPB.
  - OPB: in_ready=1. On accept, alu_b ← in_data, go to EXEC.
  - EXEC: in_ready=0, one cycle. At the end of the cycle: out_result ← alu_result, out_flags ← alu_flags, accumulator ← alu_result, out_valid ← 1. Go to OUT.
  - OUT: in_ready=0, out_valid=1. out_result and out_flags are held stable. When out_ready is high at the edge: out_valid ← 0, go to HDR.
- alu_a, alu_b, alu_ctrl and alu_samt hold their values until overwritten. out_result and out_flags hold after the handshake until the next EXEC.
- alu_ctrl and alu_samt update only when a header is accepted. alu_a updates in OPA, or in HDR when chain is effective.
- The sequencer performs no arithmetic; all widths pass through unchanged.
- Reset, when asserted in any state including mid-command:
  - state ← HDR
  - alu_a, alu_b, alu_ctrl, alu_samt, out_result, accumulator ← 0
  - out_flags ← 0, out_valid ← 0
  - Any partially received command is discarded. in_data present in the reset cycle is not accepted.
- Reset output values:
  - in_ready=1 (HDR)
  - busy=0
  - out_valid=0
  - all data outputs 0
- Chain directly after reset uses A=0x00.

## Timing
- B byte accepted at edge t: EXEC occupies cycle t..t+1. out_valid is high from edge t+1.
- Minimum command period with out_ready held high:
  - 5 cycles normal: 3 input beats, EXEC, OUT
  - 4 cycles chained
- in_ready is a pure function of state. There is no combinational path from out_ready to in_ready.
- alu_result must settle within the EXEC cycle. The ALU is purely combinational.
- A header may be accepted on the cycle immediately after the OUT handshake.

## Test plan
- Add: header 0x00, A=0x05, B=0x03.
  - out_result=0x08, out_flags=0000.
  - out_valid rises exactly one edge after the B accept.
- Subtract, equal operands: header 0x01, A=0x03, B=0x03.
  - out_result=0x00, out_flags=0011 (ZERO, CARRY).
- Subtract, negative result: header 0x01, A=0x03, B=0x05.
  - out_result=0xFE, out_flags=0100 (NEGATIVE).
- Chain then shift:
  - After the add test, header 0x80, then B=0x01: only two beats accepted, alu_a=0x08, out_result=0x09.
  - Then header 0x14 (ctrl=100, s_amt=2), A=0x03, B=0x01: out_result=0x10.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with in_valid=1 and in_data toggling.
  - out_result/out_flags stay stable, in_ready=0, busy=1, and no bytes are consumed.
  - Raise out_ready: out_valid drops next edge and in_ready returns to 1.
- Reset mid-command:
  - Send header 0x01 and A=0x7F, then pulse rst for one cycle with in_valid=1.
  - All outputs return to their reset values.
  - The next bytes 0x00, 0xFF, 0x01 give out_result=0x00 and out_flags=0011.
